// File: rtl/msrh_l1d_lrq.sv
// msrh_l1d_lrq: L1D load refill queue that tracks line misses, fetches lines from L2,
// writes them into L1D and resolves waiting loads. Define MSRH_LRQ_PERF_CNT_EN for perf counters.
module msrh_l1d_lrq #(
    parameter int LRQ_ENTRY_SIZE = 4,
    parameter int PADDR_W        = 56,
    parameter int LINE_W         = 512,
    parameter int LINE_OFS_W     = 6,
    localparam int IDX_W         = $clog2(LRQ_ENTRY_SIZE)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_load,
    input  logic [PADDR_W-1:0]        i_req_paddr,
    output logic                      o_resp_conflict,
    output logic                      o_resp_full,
    output logic [LRQ_ENTRY_SIZE-1:0] o_resp_lrq_index_oh,
    output logic                      o_l2_req_valid,
    input  logic                      i_l2_req_ready,
    output logic [PADDR_W-1:0]        o_l2_req_paddr,
    output logic [IDX_W-1:0]          o_l2_req_tag,
    input  logic                      i_l2_resp_valid,
    input  logic [IDX_W-1:0]          i_l2_resp_tag,
    input  logic [LINE_W-1:0]         i_l2_resp_data,
    output logic                      o_l1d_wr_valid,
    input  logic                      i_l1d_wr_ready,
    output logic [PADDR_W-1:0]        o_l1d_wr_paddr,
    output logic [LINE_W-1:0]         o_l1d_wr_data,
    output logic                      o_lrq_resolve_valid,
    output logic [LRQ_ENTRY_SIZE-1:0] o_lrq_resolve_index_oh
`ifdef MSRH_LRQ_PERF_CNT_EN
    ,
    output logic [31:0]               o_perf_alloc_cnt,
    output logic [31:0]               o_perf_conflict_cnt
`endif
);

    localparam int LA_W = PADDR_W - LINE_OFS_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP_WAIT,
        ST_WRITE
    } state_e;

    state_e            state_q [LRQ_ENTRY_SIZE];
    state_e            state_d [LRQ_ENTRY_SIZE];
    logic [LA_W-1:0]   addr_q  [LRQ_ENTRY_SIZE];
    logic [LA_W-1:0]   addr_d  [LRQ_ENTRY_SIZE];
    logic [LINE_W-1:0] data_q  [LRQ_ENTRY_SIZE];
    logic [LINE_W-1:0] data_d  [LRQ_ENTRY_SIZE];

    logic              l2_lock_q;
    logic              l2_lock_d;
    logic [IDX_W-1:0]  l2_lock_idx_q;
    logic [IDX_W-1:0]  l2_lock_idx_d;

    logic [LA_W-1:0]           req_line;
    logic [LRQ_ENTRY_SIZE-1:0] match_oh;
    logic                      any_match;
    logic                      free_found;
    logic [IDX_W-1:0]          free_idx;
    logic                      alloc;
    logic                      l2_valid;
    logic [IDX_W-1:0]          l2_idx;
    logic                      l2_hs;
    logic                      wr_valid;
    logic [IDX_W-1:0]          wr_idx;
    logic                      wr_hs;
    logic                      unused_paddr_ofs;

    assign req_line         = i_req_paddr[PADDR_W-1:LINE_OFS_W];
    assign unused_paddr_ofs = ^i_req_paddr[LINE_OFS_W-1:0];

    // A pending L2 request stays locked on its entry so a newer lower-index ISSUE entry cannot disturb it.
    always_comb begin
        wr_valid   = 1'b0;
        wr_idx     = '0;
        l2_valid   = 1'b0;
        l2_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = LRQ_ENTRY_SIZE - 1; i >= 0; i--) begin
            if (state_q[i] == ST_WRITE) begin
                wr_valid = 1'b1;
                wr_idx   = IDX_W'(i);
            end
            if (state_q[i] == ST_ISSUE) begin
                l2_valid = 1'b1;
                l2_idx   = IDX_W'(i);
            end
            if (state_q[i] == ST_IDLE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        if (l2_lock_q) begin
            l2_valid = 1'b1;
            l2_idx   = l2_lock_idx_q;
        end
        wr_hs = wr_valid & i_l1d_wr_ready;
        l2_hs = l2_valid & i_l2_req_ready;

        match_oh = '0;
        for (int i = 0; i < LRQ_ENTRY_SIZE; i++) begin
            match_oh[i] = (state_q[i] != ST_IDLE) && (addr_q[i] == req_line) &&
                          !(wr_hs && (wr_idx == IDX_W'(i)));
        end
        any_match = |match_oh;
        alloc     = i_load & ~any_match & free_found;
    end

    always_comb begin
        o_resp_conflict        = i_load & any_match;
        o_resp_full            = i_load & ~any_match & ~free_found;
        o_resp_lrq_index_oh    = i_load ? match_oh : '0;
        o_l2_req_valid         = l2_valid;
        o_l2_req_paddr         = l2_valid ? {addr_q[l2_idx], {LINE_OFS_W{1'b0}}} : '0;
        o_l2_req_tag           = l2_idx;
        o_l1d_wr_valid         = wr_valid;
        o_l1d_wr_paddr         = wr_valid ? {addr_q[wr_idx], {LINE_OFS_W{1'b0}}} : '0;
        o_l1d_wr_data          = wr_valid ? data_q[wr_idx] : '0;
        o_lrq_resolve_valid    = wr_hs;
        o_lrq_resolve_index_oh = wr_hs ? (LRQ_ENTRY_SIZE'(1) << wr_idx) : '0;
    end

    // Each event targets a different entry, so the per-entry updates never collide.
    always_comb begin
        for (int i = 0; i < LRQ_ENTRY_SIZE; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            data_d[i]  = data_q[i];
            if (alloc && (free_idx == IDX_W'(i))) begin
                state_d[i] = ST_ISSUE;
                addr_d[i]  = req_line;
            end
            if (l2_hs && (l2_idx == IDX_W'(i))) begin
                state_d[i] = ST_RESP_WAIT;
            end
            if (i_l2_resp_valid && (i_l2_resp_tag == IDX_W'(i)) && (state_q[i] == ST_RESP_WAIT)) begin
                state_d[i] = ST_WRITE;
                data_d[i]  = i_l2_resp_data;
            end
            if (wr_hs && (wr_idx == IDX_W'(i))) begin
                state_d[i] = ST_IDLE;
            end
        end
        l2_lock_d     = l2_valid & ~i_l2_req_ready;
        l2_lock_idx_d = l2_idx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LRQ_ENTRY_SIZE; i++) begin
                state_q[i] <= ST_IDLE;
            end
            l2_lock_q     <= 1'b0;
            l2_lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < LRQ_ENTRY_SIZE; i++) begin
                state_q[i] <= state_d[i];
            end
            l2_lock_q     <= l2_lock_d;
            l2_lock_idx_q <= l2_lock_idx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LRQ_ENTRY_SIZE; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
        end
    end

`ifdef SIMULATION
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_l2_resp_valid && (state_q[i_l2_resp_tag] != ST_RESP_WAIT)) begin
            $fatal(1, "msrh_l1d_lrq: L2 response for entry %0d which is not awaiting a refill", i_l2_resp_tag);
        end
    end
`endif

`ifdef MSRH_LRQ_PERF_CNT_EN
    logic [31:0] perf_alloc_q;
    logic [31:0] perf_alloc_d;
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_conflict_d;

    // Counters saturate rather than wrap.
    always_comb begin
        perf_alloc_d    = perf_alloc_q;
        perf_conflict_d = perf_conflict_q;
        if (alloc && (perf_alloc_q != 32'hFFFF_FFFF)) begin
            perf_alloc_d = perf_alloc_q + 32'd1;
        end
        if (o_resp_conflict && (perf_conflict_q != 32'hFFFF_FFFF)) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_alloc_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_alloc_q    <= perf_alloc_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign o_perf_alloc_cnt    = perf_alloc_q;
    assign o_perf_conflict_cnt = perf_conflict_q;
`endif

endmodule

// File: tb/tb_msrh_l1d_lrq.sv
// tb_msrh_l1d_lrq: self-checking bench for the L1D load refill queue; directed scenarios
// followed by randomized traffic, all checked against a behavioural model of the queue.
module tb_msrh_l1d_lrq;

    localparam int N          = 4;
    localparam int PADDR_W    = 56;
    localparam int LINE_W     = 512;
    localparam int LINE_OFS_W = 6;
    localparam int IDX_W      = 2;
    localparam int LA_W       = PADDR_W - LINE_OFS_W;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_load;
    logic [PADDR_W-1:0] i_req_paddr;
    logic               o_resp_conflict;
    logic               o_resp_full;
    logic [N-1:0]       o_resp_lrq_index_oh;
    logic               o_l2_req_valid;
    logic               i_l2_req_ready;
    logic [PADDR_W-1:0] o_l2_req_paddr;
    logic [IDX_W-1:0]   o_l2_req_tag;
    logic               i_l2_resp_valid;
    logic [IDX_W-1:0]   i_l2_resp_tag;
    logic [LINE_W-1:0]  i_l2_resp_data;
    logic               o_l1d_wr_valid;
    logic               i_l1d_wr_ready;
    logic [PADDR_W-1:0] o_l1d_wr_paddr;
    logic [LINE_W-1:0]  o_l1d_wr_data;
    logic               o_lrq_resolve_valid;
    logic [N-1:0]       o_lrq_resolve_index_oh;

    msrh_l1d_lrq #(
        .LRQ_ENTRY_SIZE(N),
        .PADDR_W(PADDR_W),
        .LINE_W(LINE_W),
        .LINE_OFS_W(LINE_OFS_W)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_load(i_load),
        .i_req_paddr(i_req_paddr),
        .o_resp_conflict(o_resp_conflict),
        .o_resp_full(o_resp_full),
        .o_resp_lrq_index_oh(o_resp_lrq_index_oh),
        .o_l2_req_valid(o_l2_req_valid),
        .i_l2_req_ready(i_l2_req_ready),
        .o_l2_req_paddr(o_l2_req_paddr),
        .o_l2_req_tag(o_l2_req_tag),
        .i_l2_resp_valid(i_l2_resp_valid),
        .i_l2_resp_tag(i_l2_resp_tag),
        .i_l2_resp_data(i_l2_resp_data),
        .o_l1d_wr_valid(o_l1d_wr_valid),
        .i_l1d_wr_ready(i_l1d_wr_ready),
        .o_l1d_wr_paddr(o_l1d_wr_paddr),
        .o_l1d_wr_data(o_l1d_wr_data),
        .o_lrq_resolve_valid(o_lrq_resolve_valid),
        .o_lrq_resolve_index_oh(o_lrq_resolve_index_oh)
    );

    always #5 i_clk = ~i_clk;

    // Model: 0 idle, 1 waiting to send to L2, 2 waiting for L2 data, 3 waiting to write L1D.
    int               m_state [N];
    logic [LA_W-1:0]  m_line  [N];
    logic [LINE_W-1:0] m_data [N];
    bit               m_l2_held;
    int               m_l2_held_idx;
    int               s_wi, s_li, s_fi;
    bit               s_match, s_whs, s_lhs, s_rsp;
    int               checks = 0;
    int               errors = 0;
    logic [LINE_W-1:0] dv [3];

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, LINE_W'(obs), LINE_W'(exp));
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic applyStimulus(input bit load, input logic [PADDR_W-1:0] paddr, input bit l2rdy,
                                 input bit rspv, input int rsptag, input logic [LINE_W-1:0] rspdata,
                                 input bit wrrdy);
        logic [31:0] t;
        t               = rsptag;
        i_load          = load;
        i_req_paddr     = paddr;
        i_l2_req_ready  = l2rdy;
        i_l2_resp_valid = rspv;
        i_l2_resp_tag   = t[IDX_W-1:0];
        i_l2_resp_data  = rspdata;
        i_l1d_wr_ready  = wrrdy;
    endtask

    // Expected outputs follow from the queue rules applied to the model and current inputs.
    task automatic checkOutput();
        logic [N-1:0]    moh;
        logic [LA_W-1:0] rl;
        logic [31:0]     tmp;
        rl   = i_req_paddr[PADDR_W-1:LINE_OFS_W];
        s_wi = -1;
        s_li = -1;
        s_fi = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_state[i] == 3) s_wi = i;
            if (m_state[i] == 1) s_li = i;
            if (m_state[i] == 0) s_fi = i;
        end
        if (m_l2_held) s_li = m_l2_held_idx;
        s_whs = (s_wi >= 0) && i_l1d_wr_ready;
        s_lhs = (s_li >= 0) && i_l2_req_ready;
        moh = '0;
        for (int i = 0; i < N; i++) begin
            if (m_state[i] != 0 && m_line[i] == rl && !(s_whs && s_wi == i)) moh[i] = 1'b1;
        end
        s_match = (moh != '0);
        s_rsp   = i_l2_resp_valid && (m_state[i_l2_resp_tag] == 2);
        chk1("resp_conflict", o_resp_conflict, i_load && s_match);
        chk1("resp_full", o_resp_full, i_load && !s_match && (s_fi < 0));
        chk("resp_index_oh", LINE_W'(o_resp_lrq_index_oh), LINE_W'(i_load ? moh : 4'b0000));
        chk1("l2_req_valid", o_l2_req_valid, s_li >= 0);
        if (s_li >= 0) begin
            tmp = s_li;
            chk("l2_req_paddr", LINE_W'(o_l2_req_paddr), LINE_W'({m_line[s_li], 6'h00}));
            chk("l2_req_tag", LINE_W'(o_l2_req_tag), LINE_W'(tmp[IDX_W-1:0]));
        end
        chk1("l1d_wr_valid", o_l1d_wr_valid, s_wi >= 0);
        if (s_wi >= 0) begin
            chk("l1d_wr_paddr", LINE_W'(o_l1d_wr_paddr), LINE_W'({m_line[s_wi], 6'h00}));
            chk("l1d_wr_data", o_l1d_wr_data, m_data[s_wi]);
        end
        chk1("resolve_valid", o_lrq_resolve_valid, s_whs);
        chk("resolve_index_oh", LINE_W'(o_lrq_resolve_index_oh),
            LINE_W'(s_whs ? (4'b0001 << s_wi) : 4'b0000));
    endtask

    task automatic updateModel();
        if (i_reset) begin
            for (int i = 0; i < N; i++) m_state[i] = 0;
            m_l2_held = 0;
        end else begin
            if (i_load && !s_match && s_fi >= 0) begin
                m_state[s_fi] = 1;
                m_line[s_fi]  = i_req_paddr[PADDR_W-1:LINE_OFS_W];
            end
            if (s_lhs) m_state[s_li] = 2;
            if (s_rsp) begin
                m_state[i_l2_resp_tag] = 3;
                m_data[i_l2_resp_tag]  = i_l2_resp_data;
            end
            if (s_whs) m_state[s_wi] = 0;
            m_l2_held     = (s_li >= 0) && !i_l2_req_ready;
            m_l2_held_idx = s_li;
        end
    endtask

    task automatic sampleCycle();
        @(negedge i_clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge i_clk);
        updateModel();
        #1;
    endtask

    task automatic step();
        sampleCycle();
        endCycle();
    endtask

    task automatic drainAll();
        bit busy;
        busy = 1;
        for (int c = 0; c < 60 && busy; c++) begin
            int w;
            w = -1;
            for (int i = 0; i < N; i++) if (m_state[i] == 2) w = i;
            if (w >= 0) applyStimulus(0, '0, 1, 1, w, rand_line(), 1);
            else        applyStimulus(0, '0, 1, 0, 0, '0, 1);
            step();
            busy = 0;
            for (int i = 0; i < N; i++) if (m_state[i] != 0) busy = 1;
        end
        checks++;
        assert (!busy) else begin
            errors++;
            $error("[TB] FAIL drain observed=busy expected=idle");
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_state[i] = 0;
        m_l2_held     = 0;
        m_l2_held_idx = 0;

        $display("[TB] reset");
        i_reset = 1'b1;
        applyStimulus(0, '0, 0, 0, 0, '0, 0);
        step();
        sampleCycle();
        chk1("rst_l2_valid", o_l2_req_valid, 1'b0);
        chk1("rst_wr_valid", o_l1d_wr_valid, 1'b0);
        chk1("rst_resolve", o_lrq_resolve_valid, 1'b0);
        endCycle();
        i_reset = 1'b0;

        $display("[TB] single miss and conflict");
        applyStimulus(1, 56'h8000_0048, 0, 0, 0, '0, 0);
        sampleCycle();
        chk1("t1_conflict", o_resp_conflict, 1'b0);
        chk1("t1_full", o_resp_full, 1'b0);
        chk("t1_index_oh", LINE_W'(o_resp_lrq_index_oh), LINE_W'(4'b0000));
        endCycle();
        applyStimulus(1, 56'h8000_0070, 0, 0, 0, '0, 0);
        sampleCycle();
        chk("t1_l2_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h8000_0040));
        chk("t1_l2_tag", LINE_W'(o_l2_req_tag), LINE_W'(2'd0));
        chk1("t2_conflict", o_resp_conflict, 1'b1);
        chk1("t2_full", o_resp_full, 1'b0);
        chk("t2_index_oh", LINE_W'(o_resp_lrq_index_oh), LINE_W'(4'b0001));
        endCycle();
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        step();
        dv[0] = rand_line();
        applyStimulus(0, '0, 1, 1, 0, dv[0], 0);
        sampleCycle();
        chk1("t2_no_new_l2", o_l2_req_valid, 1'b0);
        endCycle();
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        sampleCycle();
        chk1("t1_wr_valid", o_l1d_wr_valid, 1'b1);
        chk("t1_wr_paddr", LINE_W'(o_l1d_wr_paddr), LINE_W'(56'h8000_0040));
        chk("t1_wr_data", o_l1d_wr_data, dv[0]);
        chk1("t1_no_resolve", o_lrq_resolve_valid, 1'b0);
        endCycle();
        applyStimulus(0, '0, 1, 0, 0, '0, 1);
        sampleCycle();
        chk1("t1_resolve", o_lrq_resolve_valid, 1'b1);
        chk("t1_resolve_oh", LINE_W'(o_lrq_resolve_index_oh), LINE_W'(4'b0001));
        endCycle();
        applyStimulus(0, '0, 1, 0, 0, '0, 1);
        step();

        $display("[TB] full queue");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 56'h1000_0000 + 56'(k * 64), 1, 0, 0, '0, 0);
            sampleCycle();
            chk1("t3_alloc_not_full", o_resp_full, 1'b0);
            endCycle();
        end
        applyStimulus(1, 56'h1000_0100, 1, 0, 0, '0, 0);
        sampleCycle();
        chk1("t3_full", o_resp_full, 1'b1);
        chk1("t3_full_conflict", o_resp_conflict, 1'b0);
        chk("t3_full_oh", LINE_W'(o_resp_lrq_index_oh), LINE_W'(4'b0000));
        endCycle();
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        sampleCycle();
        chk1("t3_no_alloc", o_l2_req_valid, 1'b0);
        endCycle();
        applyStimulus(0, '0, 1, 1, 0, rand_line(), 0);
        step();
        applyStimulus(1, 56'h1000_0100, 1, 0, 0, '0, 1);
        sampleCycle();
        chk1("t3_resolve", o_lrq_resolve_valid, 1'b1);
        chk1("t3_freed_not_allocatable", o_resp_full, 1'b1);
        endCycle();
        applyStimulus(1, 56'h1000_0100, 1, 0, 0, '0, 0);
        sampleCycle();
        chk1("t3_realloc_full", o_resp_full, 1'b0);
        chk1("t3_realloc_conflict", o_resp_conflict, 1'b0);
        endCycle();
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        sampleCycle();
        chk1("t3_realloc_l2_valid", o_l2_req_valid, 1'b1);
        chk("t3_realloc_tag", LINE_W'(o_l2_req_tag), LINE_W'(2'd0));
        chk("t3_realloc_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h1000_0100));
        endCycle();
        drainAll();

        $display("[TB] out-of-order responses");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 56'h2000_0000 + 56'(k * 64), 1, 0, 0, '0, 0);
            step();
        end
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        step();
        for (int k = 0; k < 3; k++) dv[k] = rand_line();
        applyStimulus(0, '0, 1, 1, 2, dv[2], 0);
        step();
        applyStimulus(0, '0, 1, 1, 0, dv[0], 0);
        step();
        applyStimulus(0, '0, 1, 1, 1, dv[1], 0);
        step();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, '0, 1, 0, 0, '0, 0);
            sampleCycle();
            chk1("t4_stall_valid", o_l1d_wr_valid, 1'b1);
            chk("t4_stall_paddr", LINE_W'(o_l1d_wr_paddr), LINE_W'(56'h2000_0000));
            chk("t4_stall_data", o_l1d_wr_data, dv[0]);
            endCycle();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, '0, 1, 0, 0, '0, 1);
            sampleCycle();
            chk1("t4_resolve", o_lrq_resolve_valid, 1'b1);
            chk("t4_resolve_oh", LINE_W'(o_lrq_resolve_index_oh), LINE_W'(4'b0001 << k));
            chk("t4_wr_data", o_l1d_wr_data, dv[k]);
            endCycle();
        end

        $display("[TB] resolve with same-line request");
        applyStimulus(1, 56'h3000_0000, 1, 0, 0, '0, 0);
        step();
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        step();
        applyStimulus(0, '0, 1, 1, 0, rand_line(), 0);
        step();
        applyStimulus(1, 56'h3000_0010, 0, 0, 0, '0, 1);
        sampleCycle();
        chk1("t5_resolve", o_lrq_resolve_valid, 1'b1);
        chk("t5_resolve_oh", LINE_W'(o_lrq_resolve_index_oh), LINE_W'(4'b0001));
        chk1("t5_conflict", o_resp_conflict, 1'b0);
        chk1("t5_full", o_resp_full, 1'b0);
        endCycle();
        applyStimulus(0, '0, 0, 0, 0, '0, 0);
        sampleCycle();
        chk1("t5_l2_valid", o_l2_req_valid, 1'b1);
        chk("t5_l2_tag", LINE_W'(o_l2_req_tag), LINE_W'(2'd1));
        chk("t5_l2_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h3000_0000));
        endCycle();
        drainAll();

        $display("[TB] mid-operation reset");
        applyStimulus(1, 56'h4000_0000, 1, 0, 0, '0, 0);
        step();
        applyStimulus(1, 56'h4000_0040, 1, 0, 0, '0, 0);
        step();
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        step();
        i_reset = 1'b1;
        applyStimulus(0, '0, 1, 0, 0, '0, 1);
        step();
        applyStimulus(0, '0, 1, 1, 0, rand_line(), 1);
        sampleCycle();
        chk1("t6_rst_l2_valid", o_l2_req_valid, 1'b0);
        chk1("t6_rst_wr_valid", o_l1d_wr_valid, 1'b0);
        endCycle();
        i_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, '0, 1, 0, 0, '0, 1);
            sampleCycle();
            chk1("t6_no_write", o_l1d_wr_valid, 1'b0);
            chk1("t6_no_resolve", o_lrq_resolve_valid, 1'b0);
            chk1("t6_no_l2", o_l2_req_valid, 1'b0);
            endCycle();
        end

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            int w;
            int cnt;
            logic [PADDR_W-1:0] pa;
            w   = -1;
            cnt = 0;
            for (int i = 0; i < N; i++) begin
                if (m_state[i] == 2) begin
                    cnt++;
                    if ($urandom_range(cnt - 1, 0) == 0) w = i;
                end
            end
            pa = 56'h5000_0000 + 56'($urandom_range(5, 0) * 64) + 56'($urandom_range(63, 0));
            applyStimulus($urandom_range(1, 0) == 1, pa, $urandom_range(3, 0) != 0,
                          (w >= 0) && ($urandom_range(2, 0) != 0), (w < 0) ? 0 : w,
                          rand_line(), $urandom_range(4, 0) > 1);
            step();
        end
        drainAll();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
